// File: rtl/harm_pkg.sv
// rtl/harm_pkg.sv - shared widths, FSM states and magnitude type for harmonic_scheduler
//
// Purpose: default widths and types used by harmonic_scheduler and harm_mac.
// Ports:   none (package).
package harm_pkg;

  localparam int NUM_HARM = 15;
  localparam int PHASE_W  = 8;
  localparam int MAG_W    = 4;
  localparam int ROM_W    = 16;
  localparam int OUT_W    = 24;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } harm_state_t;

  typedef logic signed [MAG_W-1:0] mag_t;

endpackage

// File: rtl/harm_mac.sv
// rtl/harm_mac.sv - signed multiply-accumulate stage for harmonic_scheduler
//
// Purpose: acc += sext(data * mag) when en is high; clear zeroes acc and wins over en.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       zero the accumulator
//   en          accumulate this cycle's product
//   data        signed ROM sample
//   mag         signed harmonic magnitude
//   acc         signed running sum
module harm_mac #(
  parameter int ROM_W = harm_pkg::ROM_W,
  parameter int MAG_W = harm_pkg::MAG_W,
  parameter int OUT_W = harm_pkg::OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [ROM_W-1:0] data,
  input  logic signed [MAG_W-1:0] mag,
  output logic signed [OUT_W-1:0] acc
);

  localparam int PROD_W = ROM_W + MAG_W;

  logic signed [PROD_W-1:0] product;

  // Both operands are widened before multiplying so the full-width product is exact.
  assign product = PROD_W'(data) * PROD_W'(mag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + OUT_W'(product);
    end
  end

endmodule

// File: rtl/harmonic_scheduler.sv
// rtl/harmonic_scheduler.sv - shares one sync sine ROM across harmonics to build one sample per frame
//
// Purpose: on sample_tick, issue k*base addresses for k=1..NUM_HARM, weight each
//          returned sine value by its magnitude and sum into sample_out.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   sample_tick        frame start pulse
//   phase_inc          base-phase increment, latched at frame start
//   cfg_we/idx/mag     magnitude shadow-bank write (idx 1..NUM_HARM)
//   rom_addr, rom_data external ROM address (registered) and data (one cycle later)
//   sample_out         frame sum, held until the next frame completes
//   sample_valid       one-cycle pulse on sample_out update
//   busy               frame in progress
//   overrun            sticky: tick arrived while busy
module harmonic_scheduler #(
  parameter int NUM_HARM = harm_pkg::NUM_HARM,
  parameter int PHASE_W  = harm_pkg::PHASE_W,
  parameter int MAG_W    = harm_pkg::MAG_W,
  parameter int ROM_W    = harm_pkg::ROM_W,
  parameter int OUT_W    = harm_pkg::OUT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_tick,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_idx,
  input  logic signed [MAG_W-1:0]   cfg_mag,
  output logic [PHASE_W-1:0]        rom_addr,
  input  logic signed [ROM_W-1:0]   rom_data,
  output logic signed [OUT_W-1:0]   sample_out,
  output logic                      sample_valid,
  output logic                      busy,
  output logic                      overrun
);

  import harm_pkg::*;

  harm_state_t state, state_next;

  logic [PHASE_W-1:0]       base;
  logic [PHASE_W-1:0]       inc_lat;
  logic [3:0]               k;        // harmonic whose address is on rom_addr
  logic [3:0]               k_d;      // harmonic whose data is on rom_data
  logic                     rom_vld_d;
  logic signed [MAG_W-1:0]  mag_shadow [16];
  logic signed [MAG_W-1:0]  mag_active [16];
  logic signed [OUT_W-1:0]  acc;
  logic                     start;
  logic                     cfg_ok;
  logic                     last_issue;

  assign start      = (state == ST_IDLE) && sample_tick;
  assign cfg_ok     = cfg_we && (cfg_idx != 4'd0) && (cfg_idx <= 4'(NUM_HARM));
  assign last_issue = (k == 4'(NUM_HARM));
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (sample_tick) state_next = ST_ISSUE;
      ST_ISSUE: if (last_issue)  state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base         <= '0;
      inc_lat      <= '0;
      rom_addr     <= '0;
      k            <= '0;
      k_d          <= '0;
      rom_vld_d    <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mag_shadow[i] <= '0;
        mag_active[i] <= '0;
      end
    end else begin
      if (cfg_ok) begin
        mag_shadow[cfg_idx] <= cfg_mag;
      end

      if (start) begin
        inc_lat  <= phase_inc;
        rom_addr <= base;
        k        <= 4'd1;
        // A write landing on the start edge goes straight into the active copy.
        for (int i = 0; i < 16; i++) begin
          mag_active[i] <= (cfg_ok && (cfg_idx == 4'(i))) ? cfg_mag : mag_shadow[i];
        end
      end else if ((state == ST_ISSUE) && !last_issue) begin
        rom_addr <= rom_addr + base;
        k        <= k + 4'd1;
      end

      // Index travels one cycle behind the address to line up with the ROM latency.
      rom_vld_d <= (state == ST_ISSUE);
      k_d       <= k;

      sample_valid <= (state == ST_DONE);
      if (state == ST_DONE) begin
        sample_out <= acc;
        base       <= base + inc_lat;
      end

      if (sample_tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  harm_mac #(
    .ROM_W (ROM_W),
    .MAG_W (MAG_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .en    (rom_vld_d),
    .data  (rom_data),
    .mag   (mag_active[k_d]),
    .acc   (acc)
  );

endmodule
